// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler for the shared SPI monarch: issues a command/read
// transaction pair per nxt request and holds the latest 12-bit result of each channel.
module a2d_rr_sched #(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] spi_cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic            pending;
    logic [GW-1:0]   gap_cnt;
    logic [2:0]      ch;
    logic            rd_unused;

    // Upper nibble of the returned word carries no conversion data.
    assign rd_unused = ^rd_data[15:12];

    always_comb begin
        // NOTE: default assignment first so every path drives ch and no latch is inferred.
        ch = CH_LFT;
        case (ptr)
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            2'd3:    ch = CH_BATT;
            default: ch = CH_LFT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            pending   <= 1'b0;
            gap_cnt   <= '0;
            wrt       <= 1'b0;
            spi_cmd   <= 16'h0000;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            // NOTE: non-blocking everywhere so each branch decides from pre-edge state.
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            if (state != IDLE && nxt) pending <= 1'b1;

            case (state)
                IDLE: begin
                    busy <= nxt || pending;
                    if (nxt || pending) begin
                        state   <= CMD;
                        wrt     <= 1'b1;
                        spi_cmd <= {2'b00, ch, 11'h000};
                        pending <= 1'b0;
                    end
                end
                CMD: begin
                    if (done) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    // done is not expected here; a stray one must not shorten the gap.
                    if (gap_cnt == '0) begin
                        state   <= READ;
                        wrt     <= 1'b1;
                        spi_cmd <= 16'h0000;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                READ: begin
                    if (done) begin
                        case (ptr)
                            2'd0:    lft_ld    <= rd_data[11:0];
                            2'd1:    rght_ld   <= rd_data[11:0];
                            2'd2:    steer_pot <= rd_data[11:0];
                            default: batt      <= rd_data[11:0];
                        endcase
                        cnv_cmplt <= 1'b1;
                        ptr       <= ptr + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Self-checking bench for a2d_rr_sched: SPI monarch model, event logs and a transaction-level
// schedule model (start cycles derived from the rotation/pending rules with plain arithmetic).
module tb_a2d_rr_sched;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done;
    logic        wrt;
    logic        cnv_cmplt;
    logic        busy;
    logic [15:0] spi_cmd;
    logic [15:0] rd_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        m_done = 1'b0;
    logic        s_done = 1'b0;

    assign done = m_done | s_done;

    typedef struct { int cyc; logic [15:0] cmd; logic [15:0] word; } wrt_rec_t;
    typedef struct { int cyc; logic [47:0] regs; } cnv_rec_t;

    wrt_rec_t    wlog[$];
    cnv_rec_t    clog[$];
    logic        busy_at [0:8191];
    int          cyc = 0;
    int          spi_t = 4;
    bit          use_rand = 1'b0;
    logic [15:0] fixed_word = 16'h0000;
    logic [15:0] word_nxt = 16'h0000;
    int          done_cyc = -1;
    int          spur_q[$];
    int          nq[$];
    int          sq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [11:0] exp_reg [4] = '{12'h000, 12'h000, 12'h000, 12'h000};
    int          exp_ptr = 0;

    a2d_rr_sched #(.GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .spi_cmd   (spi_cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI monarch: done arrives spi_t cycles after wrt, carrying the word chosen at wrt time.
    initial begin
        rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                word_nxt = use_rand ? 16'($urandom) : fixed_word;
                wlog.push_back('{cyc, spi_cmd, word_nxt});
                done_cyc = cyc + spi_t;
            end
            m_done = (cyc == done_cyc);
            s_done = 1'b0;
            foreach (spur_q[i]) if (spur_q[i] == cyc) s_done = 1'b1;
            rd_data = word_nxt;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            busy_at[cyc & 8191] = busy;
            if (cnv_cmplt === 1'b1) clog.push_back('{cyc, {lft_ld, rght_ld, steer_pot, batt}});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        foreach (exp_reg[i]) exp_reg[i] = 12'h000;
        @(negedge clk);
    endtask

    // Drives nxt at the offsets in nq (spurious done at offsets in sq) and checks every
    // transaction, result and busy cycle against the schedule derived from the rules.
    task automatic run_seq(input int t, input string tag);
        int         starts[$];
        wrt_rec_t   w[$];
        cnv_rec_t   cv[$];
        int         d, base, span, bad;
        logic       exp_busy;
        logic [2:0] ch;
        d = 3 + 2 * t + GAP;
        foreach (nq[i]) begin
            if (starts.size() == 0 || nq[i] >= starts[$] + d) starts.push_back(nq[i]);
            else if (nq[i] > starts[$]) starts.push_back(starts[$] + d);
        end
        span = (starts.size() > 0) ? starts[$] + d + 4 : 8;
        spi_t = t;
        @(negedge clk);
        base = cyc;
        spur_q.delete();
        foreach (sq[j]) spur_q.push_back(base + sq[j]);
        for (int i = 0; i <= span; i++) begin
            nxt = 1'b0;
            foreach (nq[j]) if (nq[j] == i) nxt = 1'b1;
            @(negedge clk);
        end
        nxt = 1'b0;
        spur_q.delete();

        foreach (wlog[j]) if (wlog[j].cyc >= base && wlog[j].cyc <= base + span) w.push_back(wlog[j]);
        foreach (clog[j]) if (clog[j].cyc >= base && clog[j].cyc <= base + span) cv.push_back(clog[j]);
        check({tag, "/wrt_count"}, 64'(w.size()), 64'(2 * starts.size()));
        check({tag, "/cnv_count"}, 64'(cv.size()), 64'(starts.size()));

        foreach (starts[j]) begin
            ch = ch_tab[exp_ptr];
            if (2 * j + 1 < w.size()) begin
                check({tag, "/cmd_cycle"}, 64'(w[2*j].cyc - base), 64'(starts[j] + 1));
                check({tag, "/cmd_word"}, 64'(w[2*j].cmd), 64'({2'b00, ch, 11'h000}));
                check({tag, "/read_cycle"}, 64'(w[2*j+1].cyc - base), 64'(starts[j] + 2 + t + GAP));
                check({tag, "/read_word"}, 64'(w[2*j+1].cmd), 64'(16'h0000));
                exp_reg[exp_ptr] = w[2*j+1].word[11:0];
            end
            exp_ptr = (exp_ptr + 1) % 4;
            if (j < cv.size()) begin
                check({tag, "/cnv_cycle"}, 64'(cv[j].cyc - base), 64'(starts[j] + d));
                check({tag, "/cnv_regs"}, 64'(cv[j].regs),
                      64'({exp_reg[0], exp_reg[1], exp_reg[2], exp_reg[3]}));
            end
        end

        bad = 0;
        for (int i = 0; i <= span; i++) begin
            exp_busy = 1'b0;
            foreach (starts[j]) if (i >= starts[j] + 1 && i <= starts[j] + d) exp_busy = 1'b1;
            if (busy_at[(base + i) & 8191] !== exp_busy) bad++;
        end
        check({tag, "/busy_bad_cycles"}, 64'(bad), 64'(0));
        check({tag, "/regs_hold"}, 64'({lft_ld, rght_ld, steer_pot, batt}),
              64'({exp_reg[0], exp_reg[1], exp_reg[2], exp_reg[3]}));
    endtask

    initial begin
        int rbase, late, t, d, c, n;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/wrt", 64'(wrt), 64'(0));
        check("rst/cnv_cmplt", 64'(cnv_cmplt), 64'(0));
        check("rst/busy", 64'(busy), 64'(0));
        check("rst/spi_cmd", 64'(spi_cmd), 64'(0));
        check("rst/regs", 64'({lft_ld, rght_ld, steer_pot, batt}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversion of the left load cell
        use_rand = 1'b0;
        fixed_word = 16'hFABC;
        nq = '{2};
        run_seq(5, "single");
        check("single/lft_ld", 64'(lft_ld), 64'(12'hABC));
        check("single/others", 64'({rght_ld, steer_pot, batt}), 64'(0));

        // Full rotation from reset, each channel returning ch*0x111
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            fixed_word = 16'h111 * ch_tab[k];
            nq = '{150};
            run_seq(6, "rot");
        end
        check("rot/lft_ld", 64'(lft_ld), 64'(12'h000));
        check("rot/rght_ld", 64'(rght_ld), 64'(12'h444));
        check("rot/steer_pot", 64'(steer_pot), 64'(12'h555));
        check("rot/batt", 64'(batt), 64'(12'h666));
        fixed_word = 16'h0123;
        nq = '{3};
        run_seq(6, "fifth");
        check("fifth/channel", 64'(wlog[$-1].cmd[13:11]), 64'(3'd0));
        check("fifth/lft_ld", 64'(lft_ld), 64'(12'h123));

        // Reset in READ of the right-channel conversion; its late done must be ignored
        spi_t = 10;
        fixed_word = 16'h0777;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        repeat (17) @(negedge clk);
        check("abort/busy_before", 64'(busy), 64'(1));
        rbase = cyc;
        rst_n = 1'b0;
        #1;
        check("abort/wrt", 64'(wrt), 64'(0));
        check("abort/cnv_cmplt", 64'(cnv_cmplt), 64'(0));
        check("abort/busy", 64'(busy), 64'(0));
        check("abort/spi_cmd", 64'(spi_cmd), 64'(0));
        check("abort/regs", 64'({lft_ld, rght_ld, steer_pot, batt}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        late = 0;
        foreach (clog[i]) if (clog[i].cyc >= rbase) late++;
        check("abort/late_cnv", 64'(late), 64'(0));
        check("abort/busy_after", 64'(busy), 64'(0));
        check("abort/regs_after", 64'({lft_ld, rght_ld, steer_pot, batt}), 64'(0));
        exp_ptr = 0;
        foreach (exp_reg[i]) exp_reg[i] = 12'h000;

        // Three requests during one conversion: one kept pending, one dropped
        use_rand = 1'b1;
        nq = '{1, 4, 7};
        run_seq(8, "overlap");
        check("overlap/back_to_back", 64'(wlog[$-1].cyc), 64'(clog[$-1].cyc + 1));

        // Long SPI latency with stray done pulses in IDLE and in GAP
        nq = '{3};
        sq = '{1, 37};
        run_seq(32, "gap");
        sq.delete();
        // wrt@1 and wrt@2+T+GAP_CYC relative to nxt
        check("gap/wrt_spacing", 64'(wlog[$].cyc - wlog[$-1].cyc), 64'(32 + GAP + 1));

        // Request landing on the capture cycle
        nq = '{2, 2 + (3 + 2 * 6 + GAP) - 1};
        run_seq(6, "cap_nxt");
        check("cap_nxt/back_to_back", 64'(wlog[$-1].cyc), 64'(clog[$-1].cyc + 1));
        check("cap_nxt/next_channel", 64'(wlog[$-1].cmd[13:11]), 64'(ch_tab[(exp_ptr + 3) % 4]));

        // Randomized request streams and SPI latencies
        for (int r = 0; r < 8; r++) begin
            t = int'($urandom_range(12, 1));
            d = 3 + 2 * t + GAP;
            nq.delete();
            c = int'($urandom_range(4, 1));
            n = int'($urandom_range(6, 2));
            for (int j = 0; j < n; j++) begin
                nq.push_back(c);
                c += int'($urandom_range(d + 2, 1));
            end
            run_seq(t, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
